// File: rtl/fpu_pipeline_controller.sv
// fpu_pipeline_controller
// Sequences the four-stage FPU pipeline (S1 decode, S2 align, S3 calculate,
// S4 normalize/round). Tracks a valid bit per stage and a division flag for
// S1-S3, holds S3 while the iterative divider runs, and applies output
// backpressure.
//
// Ports:
//   clk            rising-edge clock
//   reset          asynchronous active-low reset
//   flush          synchronous pipeline flush (highest priority)
//   in_valid       operation presented at S1 input
//   in_division_op presented operation is a divide
//   in_ready       pipeline accepts the presented op this cycle
//   out_valid      S4 holds a completed result
//   out_ready      consumer takes the result this cycle
//   stall_front    stall to the S1-S3 register banks
//   stall_back     stall to the S4 register bank
//   stage_valid    bit i-1 = valid bit of stage Si
//   div_active     S3 holds a division that is still iterating
//   div_iteration  remaining divider iterations
//   idle           nothing in flight and counter at zero
module fpu_pipeline_controller #(
  parameter int unsigned DIV_ITERATIONS = 26,
  parameter int unsigned CW             = 5
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          flush,
  input  logic          in_valid,
  input  logic          in_division_op,
  output logic          in_ready,
  output logic          out_valid,
  input  logic          out_ready,
  output logic          stall_front,
  output logic          stall_back,
  output logic [3:0]    stage_valid,
  output logic          div_active,
  output logic [CW-1:0] div_iteration,
  output logic          idle
);

  localparam int unsigned NSTAGE = 4;
  localparam int unsigned NDIV   = 3;
  localparam logic [CW-1:0] CNT_LOAD = CW'(DIV_ITERATIONS - 1);

  // r_valid[i] / r_div[i] belong to stage S(i+1)
  logic [NSTAGE-1:0] r_valid;
  logic [NDIV-1:0]   r_div;
  logic [CW-1:0]     r_cnt;

  logic [NSTAGE-1:0] w_valid_nxt;
  logic [NDIV-1:0]   w_div_nxt;
  logic [CW-1:0]     w_cnt_nxt;
  logic              w_stall_back;
  logic              w_div_active;
  logic              w_stall_front;
  logic              w_accept;

  // Handshake and stall decode from current stage state
  always_comb begin
    w_stall_back  = r_valid[3] & ~out_ready;
    w_div_active  = r_valid[2] & r_div[2] & (r_cnt != '0);
    w_stall_front = w_stall_back | w_div_active;
    w_accept      = in_valid & ~w_stall_front & ~flush;
  end

  // Next-state for stage valids, division flags and iteration counter
  always_comb begin
    w_valid_nxt = r_valid;
    w_div_nxt   = r_div;
    w_cnt_nxt   = r_cnt;
    if (flush) begin
      w_valid_nxt = '0;
      w_div_nxt   = '0;
      w_cnt_nxt   = '0;
    end else begin
      // Whole front section moves or freezes together; no bubble collapsing
      if (!w_stall_front) begin
        w_valid_nxt[0] = w_accept;
        w_valid_nxt[1] = r_valid[0];
        w_valid_nxt[2] = r_valid[1];
        w_div_nxt[0]   = w_accept & in_division_op;
        w_div_nxt[1]   = r_div[0];
        w_div_nxt[2]   = r_div[1];
      end
      // A held S3 leaves a bubble behind in S4
      if (!w_stall_back) begin
        w_valid_nxt[3] = r_valid[2] & ~w_stall_front;
      end
      if (!w_stall_front && r_valid[1] && r_div[1]) begin
        w_cnt_nxt = CNT_LOAD;
      end else if (r_cnt != '0) begin
        w_cnt_nxt = r_cnt - CW'(1);
      end
    end
  end

  // State registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_valid <= '0;
      r_div   <= '0;
      r_cnt   <= '0;
    end else begin
      r_valid <= w_valid_nxt;
      r_div   <= w_div_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // Output mapping
  always_comb begin
    stall_back    = w_stall_back;
    div_active    = w_div_active;
    stall_front   = w_stall_front;
    in_ready      = ~w_stall_front & ~flush;
    out_valid     = r_valid[3];
    stage_valid   = r_valid;
    div_iteration = r_cnt;
    idle          = ~|r_valid & (r_cnt == '0);
  end

endmodule

// File: tb/tb_fpu_pipeline_controller.sv
module tb_fpu_pipeline_controller;

  localparam int unsigned DIV_N = 26;
  localparam int unsigned CW    = 5;

  logic          clk = 1'b0;
  logic          reset;
  logic          flush, in_valid, in_div, out_ready;
  logic          in_ready, out_valid, stall_front, stall_back, div_active, idle;
  logic [3:0]    stage_valid;
  logic [CW-1:0] div_iteration;

  // Second instance exercising the single-iteration divider boundary
  logic          flush1, in_valid1, in_div1, out_ready1;
  logic          in_ready1, out_valid1, stall_front1, stall_back1, div_active1, idle1;
  logic [3:0]    stage_valid1;
  logic [0:0]    div_iteration1;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  fpu_pipeline_controller #(.DIV_ITERATIONS(DIV_N), .CW(CW)) u_dut (
    .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid),
    .in_division_op(in_div), .in_ready(in_ready), .out_valid(out_valid),
    .out_ready(out_ready), .stall_front(stall_front), .stall_back(stall_back),
    .stage_valid(stage_valid), .div_active(div_active),
    .div_iteration(div_iteration), .idle(idle)
  );

  fpu_pipeline_controller #(.DIV_ITERATIONS(1), .CW(1)) u_dut1 (
    .clk(clk), .reset(reset), .flush(flush1), .in_valid(in_valid1),
    .in_division_op(in_div1), .in_ready(in_ready1), .out_valid(out_valid1),
    .out_ready(out_ready1), .stall_front(stall_front1), .stall_back(stall_back1),
    .stage_valid(stage_valid1), .div_active(div_active1),
    .div_iteration(div_iteration1), .idle(idle1)
  );

  task automatic chk(input string nm, input int got, input int exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h at %0t", nm, got, exp, $time);
    end
  endtask

  task automatic drain();
    @(negedge clk);
    in_valid = 1'b0; in_div = 1'b0; out_ready = 1'b1; flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
  endtask

  // Table vector: inputs for the cycle plus outputs expected in that cycle
  typedef struct {
    logic       iv, dv, ordy, fl;
    logic [3:0] sv;
    logic       ov, sf, sb, ir, idl;
  } vec_t;

  function automatic vec_t mk(logic iv, logic dv, logic ordy, logic fl, logic [3:0] sv,
                              logic ov, logic sf, logic sb, logic ir, logic idl);
    vec_t v;
    v.iv = iv; v.dv = dv; v.ordy = ordy; v.fl = fl; v.sv = sv;
    v.ov = ov; v.sf = sf; v.sb = sb; v.ir = ir; v.idl = idl;
    return v;
  endfunction

  vec_t tbl[24];

  // Reference model: list of in-flight ops with their stage numbers
  typedef struct {
    int stg;
    bit dv;
  } op_t;

  op_t  pipe[$];
  int   rem;
  bit   m_has3, m_div3, m_has4, m_busy, m_hb, m_hf, m_ir, m_load;
  logic [3:0] m_sv;
  int   exp_vec, got_vec;
  bit   found;

  initial begin
    reset = 1'b0; flush = 1'b0; in_valid = 1'b0; in_div = 1'b0; out_ready = 1'b1;
    flush1 = 1'b0; in_valid1 = 1'b0; in_div1 = 1'b0; out_ready1 = 1'b1;
    rem = 0;

    //             iv dv or fl  sv       ov sf sb ir idle
    tbl[0]  = mk(1, 0, 1, 0, 4'b0000, 0, 0, 0, 1, 1);
    tbl[1]  = mk(0, 0, 1, 0, 4'b0001, 0, 0, 0, 1, 0);
    tbl[2]  = mk(0, 0, 1, 0, 4'b0010, 0, 0, 0, 1, 0);
    tbl[3]  = mk(0, 0, 1, 0, 4'b0100, 0, 0, 0, 1, 0);
    tbl[4]  = mk(0, 0, 1, 0, 4'b1000, 1, 0, 0, 1, 0);
    tbl[5]  = mk(0, 0, 1, 0, 4'b0000, 0, 0, 0, 1, 1);
    tbl[6]  = mk(1, 0, 1, 0, 4'b0000, 0, 0, 0, 1, 1);
    tbl[7]  = mk(1, 0, 1, 0, 4'b0001, 0, 0, 0, 1, 0);
    tbl[8]  = mk(0, 0, 1, 0, 4'b0011, 0, 0, 0, 1, 0);
    tbl[9]  = mk(0, 0, 1, 0, 4'b0110, 0, 0, 0, 1, 0);
    tbl[10] = mk(0, 0, 0, 0, 4'b1100, 1, 1, 1, 0, 0);
    tbl[11] = mk(0, 0, 0, 0, 4'b1100, 1, 1, 1, 0, 0);
    tbl[12] = mk(0, 0, 1, 0, 4'b1100, 1, 0, 0, 1, 0);
    tbl[13] = mk(0, 0, 1, 0, 4'b1000, 1, 0, 0, 1, 0);
    tbl[14] = mk(0, 0, 1, 0, 4'b0000, 0, 0, 0, 1, 1);
    tbl[15] = mk(1, 0, 1, 0, 4'b0000, 0, 0, 0, 1, 1);
    tbl[16] = mk(1, 0, 1, 1, 4'b0001, 0, 0, 0, 0, 0);
    tbl[17] = mk(0, 0, 1, 0, 4'b0000, 0, 0, 0, 1, 1);
    tbl[18] = mk(1, 1, 1, 0, 4'b0000, 0, 0, 0, 1, 1);
    tbl[19] = mk(0, 0, 1, 0, 4'b0001, 0, 0, 0, 1, 0);
    tbl[20] = mk(0, 0, 1, 0, 4'b0010, 0, 0, 0, 1, 0);
    tbl[21] = mk(0, 0, 1, 0, 4'b0100, 0, 1, 0, 0, 0);
    tbl[22] = mk(0, 0, 1, 1, 4'b0100, 0, 1, 0, 0, 0);
    tbl[23] = mk(0, 0, 1, 0, 4'b0000, 0, 0, 0, 1, 1);

    // Reset state while reset is held
    #12;
    chk("rst_sv", int'(stage_valid), 0);
    chk("rst_ir", int'(in_ready), 1);
    chk("rst_idle", int'(idle), 1);
    chk("rst_cnt", int'(div_iteration), 0);
    @(negedge clk);
    reset = 1'b1;

    // Table-driven cycle vectors
    for (int i = 0; i < 24; i++) begin
      @(negedge clk);
      in_valid = tbl[i].iv; in_div = tbl[i].dv; out_ready = tbl[i].ordy; flush = tbl[i].fl;
      #1;
      chk($sformatf("tbl%0d_sv", i), int'(stage_valid), int'(tbl[i].sv));
      chk($sformatf("tbl%0d_ov", i), int'(out_valid), int'(tbl[i].ov));
      chk($sformatf("tbl%0d_sf", i), int'(stall_front), int'(tbl[i].sf));
      chk($sformatf("tbl%0d_sb", i), int'(stall_back), int'(tbl[i].sb));
      chk($sformatf("tbl%0d_ir", i), int'(in_ready), int'(tbl[i].ir));
      chk($sformatf("tbl%0d_idle", i), int'(idle), int'(tbl[i].idl));
    end

    // Single divide: 25 iterating cycles, result 29 cycles after accept
    drain();
    @(negedge clk); in_valid = 1'b1; in_div = 1'b1;
    for (int n = 0; n < 31; n++) begin
      @(negedge clk);
      if (n == 0) begin in_valid = 1'b0; in_div = 1'b0; end
      #1;
      chk($sformatf("div_da n=%0d", n), int'(div_active), int'(n >= 2 && n <= 26));
      chk($sformatf("div_ir n=%0d", n), int'(in_ready), int'(!(n >= 2 && n <= 26)));
      if (n >= 2 && n <= 26) chk($sformatf("div_cnt n=%0d", n), int'(div_iteration), 27 - n);
      chk($sformatf("div_ov n=%0d", n), int'(out_valid), int'(n == 28));
    end

    // Divide then ADD: ADD result directly follows the divide result
    drain();
    @(negedge clk); in_valid = 1'b1; in_div = 1'b1;
    for (int n = 0; n < 33; n++) begin
      @(negedge clk);
      if (n == 0) in_div = 1'b0;
      if (n == 1) in_valid = 1'b0;
      #1;
      if (n == 0) chk("divadd_ir", int'(in_ready), 1);
      chk($sformatf("divadd_ov n=%0d", n), int'(out_valid), int'(n == 28 || n == 29));
    end

    // Stream of 8 non-division ops at full throughput
    drain();
    @(negedge clk); in_valid = 1'b1; in_div = 1'b0;
    for (int n = 0; n < 14; n++) begin
      @(negedge clk);
      if (n == 7) in_valid = 1'b0;
      #1;
      if (n < 7) chk($sformatf("strm_ir n=%0d", n), int'(in_ready), 1);
      chk($sformatf("strm_ov n=%0d", n), int'(out_valid), int'(n >= 3 && n <= 10));
    end

    // Back-to-back divisions: second waits in S2, counter reloads
    drain();
    @(negedge clk); in_valid = 1'b1; in_div = 1'b1;
    for (int n = 0; n < 58; n++) begin
      @(negedge clk);
      if (n == 1) begin in_valid = 1'b0; in_div = 1'b0; end
      #1;
      chk($sformatf("b2b_ov n=%0d", n), int'(out_valid), int'(n == 28 || n == 54));
      if (n == 27) chk("b2b_da_done", int'(div_active), 0);
      if (n == 28) chk("b2b_reload", int'(div_iteration), 25);
    end

    // Flush during the 10th divide iteration
    drain();
    @(negedge clk); in_valid = 1'b1; in_div = 1'b1;
    found = 1'b0;
    for (int n = 0; n < 40 && !found; n++) begin
      @(negedge clk);
      in_valid = 1'b0; in_div = 1'b0;
      #1;
      if (div_active && div_iteration == CW'(16)) found = 1'b1;
    end
    chk("flush_reached_iter10", int'(found), 1);
    flush = 1'b1; in_valid = 1'b1;
    #1;
    chk("flush_ir", int'(in_ready), 0);
    @(negedge clk); flush = 1'b0; in_valid = 1'b0;
    #1;
    chk("flush_sv", int'(stage_valid), 0);
    chk("flush_cnt", int'(div_iteration), 0);
    chk("flush_idle", int'(idle), 1);
    for (int n = 0; n < 5; n++) begin
      @(negedge clk); #1;
      chk($sformatf("flush_ov n=%0d", n), int'(out_valid), 0);
    end

    // Asynchronous reset mid-stream, checked before any clock edge
    @(negedge clk); in_valid = 1'b1; in_div = 1'b0;
    @(negedge clk); in_div = 1'b1;
    @(negedge clk); in_valid = 1'b0; in_div = 1'b0;
    @(negedge clk);
    #2 reset = 1'b0;
    #1;
    chk("arst_sv", int'(stage_valid), 0);
    chk("arst_ov", int'(out_valid), 0);
    chk("arst_ir", int'(in_ready), 1);
    chk("arst_sf", int'(stall_front), 0);
    chk("arst_cnt", int'(div_iteration), 0);
    chk("arst_idle", int'(idle), 1);
    @(negedge clk); reset = 1'b1;
    for (int n = 0; n < 5; n++) begin
      @(negedge clk); #1;
      chk($sformatf("arst_after_ov n=%0d", n), int'(out_valid), 0);
    end

    // Single-iteration divider: same latency as a non-division op
    @(negedge clk); in_valid1 = 1'b1; in_div1 = 1'b1;
    for (int n = 0; n < 7; n++) begin
      @(negedge clk);
      if (n == 0) begin in_valid1 = 1'b0; in_div1 = 1'b0; end
      #1;
      chk($sformatf("d1_ov n=%0d", n), int'(out_valid1), int'(n == 3));
      chk($sformatf("d1_sf n=%0d", n), int'(stall_front1), 0);
    end

    // Randomized run against the op-list model
    @(negedge clk); reset = 1'b0;
    @(negedge clk); reset = 1'b1;
    pipe.delete();
    rem = 0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      @(negedge clk);
      in_valid  = ($urandom_range(0, 99) < 60);
      in_div    = ($urandom_range(0, 9) < 2);
      out_ready = ($urandom_range(0, 99) < 80);
      flush     = ($urandom_range(0, 199) == 0);
      #1;
      m_sv = '0; m_has3 = 1'b0; m_div3 = 1'b0; m_has4 = 1'b0;
      foreach (pipe[k]) begin
        m_sv[pipe[k].stg - 1] = 1'b1;
        if (pipe[k].stg == 3) begin m_has3 = 1'b1; m_div3 = pipe[k].dv; end
        if (pipe[k].stg == 4) m_has4 = 1'b1;
      end
      m_busy = m_has3 && m_div3 && (rem > 0);
      m_hb   = m_has4 && !out_ready;
      m_hf   = m_hb || m_busy;
      m_ir   = !m_hf && !flush;
      exp_vec = {18'd0, m_ir, m_has4, m_hf, m_hb, m_busy, m_sv, 5'(rem)};
      got_vec = {18'd0, in_ready, out_valid, stall_front, stall_back, div_active,
                 stage_valid, div_iteration};
      chk($sformatf("rnd cyc=%0d {ir,ov,sf,sb,da,sv,cnt}", cyc), got_vec, exp_vec);
      if (flush) begin
        pipe.delete();
        rem = 0;
      end else begin
        m_load = 1'b0;
        if (m_has4 && !m_hb) begin
          for (int k = 0; k < pipe.size(); k++)
            if (pipe[k].stg == 4) begin pipe.delete(k); break; end
        end
        if (!m_hf) begin
          foreach (pipe[k]) begin
            pipe[k].stg = pipe[k].stg + 1;
            if (pipe[k].stg == 3 && pipe[k].dv) m_load = 1'b1;
          end
        end
        if (m_load) rem = DIV_N - 1;
        else if (rem > 0) rem = rem - 1;
        if (in_valid && m_ir) pipe.push_back('{stg: 1, dv: in_div});
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fpu_pipeline_controller.md
Name: fpu_pipeline_controller

Overview:
- Sequences the four-stage FPU pipeline: S1 decode, S2 align, S3 calculate, S4 normalize/round.
- Tracks a valid bit and a division flag per stage.
- Holds S3 for the iterative divider and applies output backpressure.
- Drives the stall inputs of the stage register banks, plus the division iteration counter and the issue/result handshakes.

Parameters:
- DIV_ITERATIONS, 26: cycles S3 occupies for a division op; legal range ≥1.
- CW, 5: iteration counter width; must satisfy 2^CW > DIV_ITERATIONS-1.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-low reset (asserted at 0).
- flush  in  1  synchronous pipeline flush.
- in_valid  in  1  an operation is presented at S1 input.
- in_division_op  in  1  the presented operation is a divide; sampled when the op is accepted.
- in_ready  out  1  the pipeline accepts the presented op this cycle.
- out_valid  out  1  S4 holds a completed result.
- out_ready  in  1  the consumer takes the result this cycle.
- stall_front  out  1  stall to the S1–S3 register banks.
- stall_back  out  1  stall to the S4 register bank.
- stage_valid  out  4  bit i-1 = valid bit of stage Si.
- div_active  out  1  S3 holds a division that is still iterating.
- div_iteration  out  CW  remaining iteration count, for the S3 divider datapath.
- idle  out  1  no valid op anywhere and counter is 0.

Behaviour:
- Reset (reset=0, async): v[4:1]=0, d[3:1]=0, cnt=0.
  - Resulting outputs: out_valid=0, stall_front=0, stall_back=0, in_ready=1, div_active=0, div_iteration=0, idle=1.
- Combinational outputs:
  - stall_back = v4 & ~out_ready.
  - div_active = v3 & d3 & (cnt != 0).
  - stall_front = stall_back | div_active.
  - in_ready = ~stall_front & ~flush.
  - out_valid = v4.
  - idle = ~|v & (cnt == 0).
- Accept = in_valid & in_ready.
- When stall_front=0, on each edge: v1<=accept, d1<=accept & in_division_op, v2/d2<=v1/d1, v3/d3<=v2/d2.
- When stall_front=1, v1..v3 and d1..d3 hold.
- No bubble collapsing: a stall freezes all of S1–S3, including empty stages.
- S4 when stall_back=0: v4 <= v3 & ~div_active.
  - An iterating S3 therefore inserts a bubble into S4.
  - A completed S3 op advances only if stall_front=0; otherwise v4<=0.
- S4 when stall_back=1: v4 holds.
- Counter:
  - Loaded with DIV_ITERATIONS-1 on the edge where d2 & v2 advance into S3.
  - Otherwise decrements when cnt != 0, regardless of stall_back.
  - Saturates at 0.
- Latency, op accepted at edge T:
  - Non-division op: out_valid=1 in the cycle after edge T+3 (4 cycles) with no backpressure.
  - Division op: S3 is held until cnt reaches 0; out_valid after 3+DIV_ITERATIONS cycles.
  - DIV_ITERATIONS=1 gives no hold, i.e. the same latency as a non-division op.
- Back-to-back divisions:
  - The second division waits in S2 while the first iterates.
  - The counter reloads on the edge the second enters S3.
- stall_back with S3 division finished (cnt=0):
  - stall_front=1, so S3 holds its finished op.
  - cnt stays 0; div_active=0.
- Flush (sync, highest priority):
  - On the edge: v[4:1]=0, d=0, cnt=0; overrides stall and accept.
  - in_ready=0 during the flush cycle; nothing is accepted.
- Reset mid-division: immediate clear to the reset values above; no partial result is emitted.
- Simultaneous out_ready and new completion: S4 takes the new op on the same edge the old result is consumed, giving full throughput of 1 op/cycle for non-division streams.

Test Plan:
- Single ADD: in_valid=1 for 1 cycle, out_ready=1 -> out_valid pulses 1 cycle, 4 cycles after accept; stall_front never 1; idle returns to 1.
- Stream: 8 consecutive non-division ops, out_ready=1 -> 8 consecutive out_valid cycles starting at cycle 4; in_ready constantly 1.
- Single divide, DIV_ITERATIONS=26 -> div_iteration counts 25..1 with div_active=1 for 25 cycles; in_ready=0 for those cycles; out_valid 29 cycles after accept.
- Divide followed by ADD -> ADD's out_valid exactly 1 cycle after the divide's result; exactly 25 bubbles precede the divide's result.
- Backpressure: 3 ops, out_ready=0 for 6 cycles after the first result -> out_valid held with stage_valid constant; in_ready=0; on release, 3 results on consecutive cycles.
- Flush during divide iteration 10, then async reset asserted mid-stream -> next cycle stage_valid=0, cnt=0, idle=1, no out_valid; reset drives outputs to reset values without a clock edge.
